// File: rtl/fp_cmp_issue_buffer.sv
// fp_cmp_issue_buffer: credit-based issue into a fixed-latency FP comparator
// with an in-order result FIFO and predicate evaluation on capture.
module fp_cmp_issue_buffer #(
  parameter int TAG_W       = 4,
  parameter int DEPTH       = 8,
  parameter int CMP_LATENCY = 3,
  parameter int TOKEN_W     = TAG_W + 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_a,
  input  logic [31:0]        req_b,
  input  logic [2:0]         req_op,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [TOKEN_W-1:0] cmp_go,
  output logic [31:0]        cmp_a,
  output logic [31:0]        cmp_b,
  input  logic [TOKEN_W-1:0] cmp_done,
  input  logic [2:0]         cmp_flags,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_bool,
  output logic [2:0]         resp_flags,
  output logic [TAG_W-1:0]   resp_tag,
  output logic               overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = (CMP_LATENCY > 0) ? $clog2(CMP_LATENCY + 1) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);
  localparam logic [DW-1:0] D_INIT  = DW'(CMP_LATENCY);

  logic [DEPTH-1:0][2:0]       r_flags;
  logic [DEPTH-1:0][TAG_W-1:0] r_tag;
  logic [DEPTH-1:0]            r_bool;
  logic [PW-1:0]               r_wr;
  logic [PW-1:0]               r_rd;
  logic [CW-1:0]               r_cnt;
  logic [CW-1:0]               r_used;
  logic [DW-1:0]               r_drain;
  logic                        r_ovf;

  logic             w_fire;
  logic             w_pop;
  logic             w_wr;
  logic             w_full;
  logic             w_push;
  logic             w_unord;
  logic             w_pred;
  logic [2:0]       w_op;
  logic [TAG_W-1:0] w_tag;

  assign req_ready = (r_drain == '0) && (r_used < C_DEPTH);
  assign w_fire    = req_valid && req_ready;
  assign cmp_go    = w_fire ? {req_tag, req_op, 1'b1} : '0;
  assign cmp_a     = req_a;
  assign cmp_b     = req_b;

  assign resp_valid = (r_cnt != '0);
  assign resp_flags = r_flags[r_rd];
  assign resp_tag   = r_tag[r_rd];
  assign resp_bool  = r_bool[r_rd];
  assign overflow   = r_ovf;

  // Returning tokens are ignored until stale pipeline contents have drained.
  assign w_pop  = resp_valid && resp_ready;
  assign w_wr   = cmp_done[0] && (r_drain == '0);
  assign w_full = (r_cnt == C_DEPTH);
  assign w_push = w_wr && (!w_full || w_pop);
  assign w_op   = cmp_done[3:1];
  assign w_tag  = cmp_done[TOKEN_W-1:4];

  always_comb begin
    w_unord = (cmp_flags == 3'b000);
    w_pred  = 1'b0;
    case (w_op)
      3'd0:    w_pred = cmp_flags[1];
      3'd1:    w_pred = !cmp_flags[1];
      3'd2:    w_pred = cmp_flags[0];
      3'd3:    w_pred = cmp_flags[0] | cmp_flags[1];
      3'd4:    w_pred = cmp_flags[2];
      3'd5:    w_pred = cmp_flags[2] | cmp_flags[1];
      3'd6:    w_pred = !w_unord;
      default: w_pred = w_unord;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
      r_tag   <= '0;
      r_bool  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_used  <= '0;
      r_drain <= D_INIT;
      r_ovf   <= 1'b0;
    end else begin
      if (r_drain != '0)
        r_drain <= r_drain - 1'b1;
      if (w_fire && !w_pop)
        r_used <= r_used + 1'b1;
      else if (!w_fire && w_pop)
        r_used <= r_used - 1'b1;
      if (w_push) begin
        r_flags[r_wr] <= cmp_flags;
        r_tag[r_wr]   <= w_tag;
        r_bool[r_wr]  <= w_pred;
        r_wr <= (r_wr == P_LAST) ? '0 : r_wr + 1'b1;
      end
      if (w_pop)
        r_rd <= (r_rd == P_LAST) ? '0 : r_rd + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;
      if (w_wr && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_cmp_issue_buffer.sv
// tb_fp_cmp_issue_buffer: drives fp_cmp_issue_buffer against a behavioural
// comparator and a queue-based reference of outstanding compare results.
module tb_fp_cmp_issue_buffer;
  localparam int TAG_W = 4;
  localparam int DEPTH = 8;
  localparam int L     = 3;
  localparam int TW    = TAG_W + 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [2:0]       req_op = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [TW-1:0]    cmp_go;
  logic [31:0]      cmp_a;
  logic [31:0]      cmp_b;
  logic [TW-1:0]    cmp_done;
  logic [2:0]       cmp_flags;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic             resp_bool;
  logic [2:0]       resp_flags;
  logic [TAG_W-1:0] resp_tag;
  logic             overflow;

  fp_cmp_issue_buffer #(
    .TAG_W(TAG_W), .DEPTH(DEPTH), .CMP_LATENCY(L), .TOKEN_W(TW)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .cmp_go(cmp_go), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_done(cmp_done), .cmp_flags(cmp_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_bool(resp_bool), .resp_flags(resp_flags),
    .resp_tag(resp_tag), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  function automatic bit is_nan(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Sign-magnitude to a signed ordering key; +0 and -0 map to the same key.
  function automatic longint fkey(logic [31:0] x);
    longint m;
    m = longint'({33'b0, x[30:0]});
    return x[31] ? -m : m;
  endfunction

  function automatic logic [2:0] ref_flags(logic [31:0] a, logic [31:0] b);
    longint ka, kb;
    if (is_nan(a) || is_nan(b)) return 3'b000;
    ka = fkey(a);
    kb = fkey(b);
    return {ka > kb, ka == kb, ka < kb};
  endfunction

  function automatic logic ref_pred(logic [31:0] a, logic [31:0] b,
                                    logic [2:0] op);
    bit n;
    longint ka, kb;
    n  = is_nan(a) || is_nan(b);
    ka = fkey(a);
    kb = fkey(b);
    case (op)
      3'd0:    return !n && (ka == kb);
      3'd1:    return n || (ka != kb);
      3'd2:    return !n && (ka < kb);
      3'd3:    return !n && (ka <= kb);
      3'd4:    return !n && (ka > kb);
      3'd5:    return !n && (ka >= kb);
      3'd6:    return !n;
      default: return n;
    endcase
  endfunction

  // Behavioural comparator: not reset, so stale tokens survive a reset.
  logic [L-1:0][TW-1:0] pipe_tok;
  logic [L-1:0][2:0]    pipe_fl;
  logic                 force_on = 1'b0;

  always @(posedge clock) begin
    pipe_tok <= {pipe_tok[L-2:0], cmp_go};
    pipe_fl  <= {pipe_fl[L-2:0], ref_flags(cmp_a, cmp_b)};
  end

  assign cmp_done  = force_on ? {4'hA, 3'd0, 1'b1} : pipe_tok[L-1];
  assign cmp_flags = force_on ? 3'b010 : pipe_fl[L-1];

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [2:0]       fl;
    logic             b;
    int               due;
  } item_t;

  item_t infl[$];
  item_t rq[$];
  int    cyc = 0;
  int    drain_m = 0;
  bit    last_fire;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, advance model.
  task automatic step(input bit want, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] op,
                      input logic [TAG_W-1:0] tag, input bit rdy);
    bit    exp_rdy;
    item_t it;
    exp_rdy = (drain_m == 0) && ((infl.size() + rq.size()) < DEPTH);
    chk("req_ready", req_ready, exp_rdy);
    chk("resp_valid", resp_valid, rq.size() != 0);
    chk("overflow_clear", overflow, 0);
    if (rq.size() != 0) begin
      chk("resp_tag", resp_tag, rq[0].tag);
      chk("resp_flags", resp_flags, rq[0].fl);
      chk("resp_bool", resp_bool, rq[0].b);
    end
    req_valid  = want;
    req_a      = a;
    req_b      = b;
    req_op     = op;
    req_tag    = tag;
    resp_ready = rdy;
    #1;
    last_fire = want && exp_rdy;
    if (last_fire) begin
      chk("cmp_go", cmp_go, {tag, op, 1'b1});
      chk("cmp_a", cmp_a, a);
      chk("cmp_b", cmp_b, b);
      it.tag = tag;
      it.fl  = ref_flags(a, b);
      it.b   = ref_pred(a, b, op);
      it.due = cyc + 1 + L;
      infl.push_back(it);
    end else begin
      chk("cmp_go_idle", cmp_go, 0);
    end
    @(posedge clock);
    cyc++;
    if (rdy && rq.size() != 0) void'(rq.pop_front());
    if (drain_m > 0) drain_m--;
    while (infl.size() != 0 && infl[0].due <= cyc)
      rq.push_back(infl.pop_front());
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 32'h0, 3'd0, '0, rdy);
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while ((infl.size() + rq.size()) != 0 && n < 60) begin
      idle(1'b1);
      n++;
    end
    chk("drain_timeout", n < 60, 1);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cmp_go", cmp_go, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_bool", resp_bool, 0);
    chk("rst_resp_flags", resp_flags, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clock);
    cyc++;
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    infl.delete();
    rq.delete();
    drain_m = L;
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [TAG_W-1:0] tag,
                          input logic [2:0] efl, input logic eb);
    step(1'b1, a, b, op, tag, 1'b0);
    for (int i = 0; i < L - 1; i++) idle(1'b0);
    chk("dir_not_early", resp_valid, 0);
    idle(1'b0);
    chk("dir_valid", resp_valid, 1);
    chk("dir_flags", resp_flags, efl);
    chk("dir_bool", resp_bool, eb);
    chk("dir_tag", resp_tag, tag);
    drain_all();
  endtask

  function automatic logic [31:0] rnd_fp();
    case ($urandom_range(0, 7))
      0:       return 32'h3F800000;
      1:       return 32'h40000000;
      2:       return 32'hBF800000;
      3:       return 32'h00000000;
      4:       return 32'h80000000;
      5:       return 32'h7FC00000;
      6:       return 32'h7F800000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int sent;
    #2;
    do_reset();
    for (int i = 0; i < L + 1; i++) idle(1'b0);

    directed(32'h3F800000, 32'h40000000, 3'd2, 4'd5, 3'b001, 1'b1);
    directed(32'h3F800000, 32'h40000000, 3'd5, 4'd6, 3'b001, 1'b0);
    directed(32'h7FC00000, 32'h3F800000, 3'd0, 4'd1, 3'b000, 1'b0);
    directed(32'h7FC00000, 32'h3F800000, 3'd1, 4'd2, 3'b000, 1'b1);
    directed(32'h7FC00000, 32'h3F800000, 3'd6, 4'd3, 3'b000, 1'b0);
    directed(32'h7FC00000, 32'h3F800000, 3'd7, 4'd4, 3'b000, 1'b1);
    directed(32'h80000000, 32'h00000000, 3'd3, 4'd7, 3'b010, 1'b1);

    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (req_ready === 1'b1) n++;
      step(1'b1, rnd_fp(), rnd_fp(), 3'(i), 4'(i), 1'b1);
    end
    chk("tp_ready_cycles", n, 16);
    n = 0;
    for (int i = 0; i < L + 1; i++) begin
      if (resp_valid === 1'b1) n++;
      idle(1'b1);
    end
    chk("tp_tail_responses", n, L + 1);
    drain_all();

    n = 0;
    sent = 0;
    for (int i = 0; i < 15; i++) begin
      if (req_ready === 1'b1) n++;
      step(1'b1, rnd_fp(), rnd_fp(), 3'($urandom), 4'(sent), 1'b0);
      if (last_fire) sent++;
    end
    chk("bp_accepted", n, DEPTH);
    chk("bp_overflow", overflow, 0);
    for (int i = 0; i < 20; i++) begin
      step(sent < 10, rnd_fp(), rnd_fp(), 3'($urandom), 4'(sent), 1'b1);
      if (last_fire) sent++;
    end
    drain_all();

    for (int i = 0; i < 3; i++)
      step(1'b1, rnd_fp(), rnd_fp(), 3'd0, 4'(9 + i), 1'b0);
    do_reset();
    for (int i = 0; i < L + 4; i++) idle(1'b1);
    directed(32'h40000000, 32'h3F800000, 3'd4, 4'd12, 3'b100, 1'b1);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, rnd_fp(), rnd_fp(), 3'($urandom),
           4'($urandom), $urandom_range(0, 3) != 0);
    drain_all();

    do_reset();
    for (int i = 0; i < L + 2; i++) idle(1'b0);
    force_on = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk("ovf_before", overflow, 0);
      @(posedge clock);
      cyc++;
      #1;
    end
    force_on = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_full_valid", resp_valid, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("ovf_sticky", overflow, 1);
    resp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid === 1'b1) begin
        n++;
        chk("ovf_entry_tag", resp_tag, 4'hA);
      end
      @(posedge clock);
      #1;
    end
    chk("ovf_kept_entries", n, DEPTH);
    chk("ovf_sticky_after_pop", overflow, 1);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
